channel_arbiter: RTL and testbench
==================================

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesting channels (N >= 2, need not be a power of 2).
REQ-002 Parameter WIDTH, default 8: data width per channel.
REQ-003 Parameter SEL_WIDTH, default $clog2(N): width of the channel index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-channel request, level; the requester holds it until its ack.
REQ-007 data_in  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 out_valid  output  1  out_data/out_sel hold a granted word.
REQ-009 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high at a rising edge.
REQ-010 out_data  output  WIDTH  captured word of the granted channel.
REQ-011 out_sel  output  SEL_WIDTH  index of the granted channel.
REQ-012 ack  output  N  one-hot, one-cycle completion pulse to the granted channel.
REQ-013 busy  output  1  high while in state GRANT.

Function
REQ-014 The block SHALL implement two states: IDLE and GRANT.
REQ-015 In IDLE, with any eligible req bit set, the block SHALL choose the first eligible channel at or after rr_ptr (ascending, wrapping N-1 -> 0) and enter GRANT at the next edge.
REQ-016 Eligible SHALL mean req[i]=1 and ack[i]=0 in that cycle, so the channel being acknowledged cannot be re-granted in its ack cycle.
REQ-017 On entering GRANT, the block SHALL register out_sel to the chosen index, register out_data to data_in[idx*WIDTH +: WIDTH] through the internal param_mux, and assert out_valid.
REQ-018 Latency SHALL be one cycle: an eligible req sampled at edge k gives out_valid=1 after edge k.
REQ-019 In GRANT, out_data and out_sel SHALL stay stable until acceptance, even if data_in or req changes.
REQ-020 If req of the granted channel drops during GRANT, the captured word SHALL still be delivered and acked (the grant is committed).
REQ-021 On acceptance, the block SHALL return to IDLE at that edge, clear out_valid, set ack[out_sel]=1 for exactly the next cycle, and set rr_ptr to out_sel+1 (with N-1 wrapping to 0).
REQ-022 With no eligible request, the block SHALL remain in IDLE with out_valid=0 and ack=0.
REQ-023 Sustained throughput SHALL be at most one word per two cycles; with out_ready tied high every requester SHALL be served within N grants.
REQ-024 ack SHALL never have more than one bit set.
REQ-025 out_sel SHALL never exceed N-1, including for non-power-of-2 N.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL set state=IDLE, rr_ptr=0, out_valid=0, out_sel=0, out_data=0, ack=0 and busy=0.
REQ-027 Reset asserted during GRANT SHALL drop the pending word without generating an ack, and out_valid SHALL be 0 in the cycle after that edge.
REQ-028 reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 The state enumeration (IDLE, GRANT) SHALL reside in a shared package, arb_pkg.
REQ-030 The round-robin next-index function SHALL also reside in arb_pkg.
REQ-031 Data selection SHALL use one instance of the existing param_mux with N and WIDTH passed through; no other sub-module is required.

Verification
REQ-032 Single request: data_in={A0,B1,C2,D3}, req=0100 -> out_valid next cycle with out_sel=2 and out_data=B1; with out_ready=1, ack=0100 for one cycle.
REQ-033 All requesting, out_ready=1: req=1111 held -> grant order 0,1,2,3,0 with out_data D3,C2,B1,A0,D3.
REQ-034 Backpressure: grant ch1, out_ready=0 for 5 cycles while data_in changes -> out_data stays C2, no ack; ack=0010 one cycle after out_ready rises.
REQ-035 Withdrawn request: ch3 granted, then req=0000 -> A0 still delivered, ack=1000, then IDLE with out_valid=0.
REQ-036 Reset mid-grant: rst=1 during GRANT on ch2 -> next cycle out_valid=0 and ack=0; after release, req=0001 is granted ch0 (rr_ptr=0).
REQ-037 N=3: req=111 over 6 grants -> order 0,1,2,0,1,2, out_sel never 3, and ack is always one-hot.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin channel arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Index following idx in an n-entry ring.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/param_mux.sv
// N-to-1 word selector over a packed bus of N words of WIDTH bits.
module param_mux #(
   parameter int unsigned N         = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SEL_WIDTH = $clog2(N)
) (
   input  logic [N*WIDTH-1:0]   data_in,
   input  logic [SEL_WIDTH-1:0] sel,
   output logic [WIDTH-1:0]     data_out
);

   always_comb begin
      data_out = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == SEL_WIDTH'(i)) data_out = data_in[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/channel_arbiter.sv
// Round-robin arbiter: captures one channel's word, holds it until downstream
// accepts, then pulses ack to that channel and advances the priority pointer.
module channel_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SEL_WIDTH = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   data_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_sel,
   output logic [N-1:0]         ack,
   output logic                 busy
);

   arb_state_t           state;
   arb_state_t           state_next;
   logic [SEL_WIDTH-1:0] rr_ptr;
   logic [SEL_WIDTH-1:0] pick;
   logic                 found;
   logic [N-1:0]         eligible;
   logic [N-1:0]         shifted;
   logic [WIDTH-1:0]     mux_data;
   logic                 accept;
   int unsigned          idx;

   // A channel in its ack cycle is masked so it cannot be granted twice for one request.
   assign eligible  = req & ~ack;
   assign accept    = (state == GRANT) && out_ready;
   assign busy      = (state == GRANT);
   assign out_valid = (state == GRANT);

   always_comb begin
      found   = 1'b0;
      pick    = '0;
      idx     = 0;
      shifted = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         shifted = eligible >> idx;
         if (!found && shifted[0]) begin
            found = 1'b1;
            pick  = SEL_WIDTH'(idx);
         end
      end
   end

   param_mux #(
      .N        (N),
      .WIDTH    (WIDTH),
      .SEL_WIDTH(SEL_WIDTH)
   ) u_mux (
      .data_in (data_in),
      .sel     (pick),
      .data_out(mux_data)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = GRANT;
         GRANT:   if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         out_sel  <= '0;
         out_data <= '0;
         ack      <= '0;
      end else begin
         ack <= '0;
         if (state == IDLE && found) begin
            out_sel  <= pick;
            out_data <= mux_data;
         end
         if (accept) begin
            ack    <= N'(1) << out_sel;
            rr_ptr <= SEL_WIDTH'(rr_next(32'(out_sel), N));
         end
      end
   end

endmodule

// File: tb/tb_channel_arbiter.sv
// Scoreboard bench for channel_arbiter at N=4 and N=3.
module tb_channel_arbiter;

   typedef struct {
      int unsigned sel;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] data_in = 32'hA0B1C2D3;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic [3:0]  ack;
   logic        busy;

   logic [2:0]  req3 = '0;
   logic [23:0] data3 = 24'h112233;
   logic        ready3 = 1'b1;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic [1:0]  out_sel3;
   logic [2:0]  ack3;
   logic        busy3;

   exp_t        q[$];
   exp_t        q3[$];
   logic [3:0]  exp_ack = '0;
   bit          auto_drop = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   channel_arbiter #(.N(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sel(out_sel), .ack(ack), .busy(busy)
   );

   channel_arbiter #(.N(3), .WIDTH(8)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .data_in(data3),
      .out_valid(out_valid3), .out_ready(ready3), .out_data(out_data3),
      .out_sel(out_sel3), .ack(ack3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) $display("FAIL %s: got %0h expected %0h", tag, got, want);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_drop) req = req & ~ack;
   endtask

   task automatic push(input int unsigned s, input logic [7:0] d);
      exp_t e;
      e.sel  = s;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic push3(input int unsigned s, input logic [7:0] d);
      exp_t e;
      e.sel  = s;
      e.data = d;
      q3.push_back(e);
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned n = 0;
      while (q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      q.delete();
   endtask

   // N=4 monitor: words compared to the queue head every valid cycle, ack one cycle after acceptance.
   always @(negedge clk) begin
      check("ack", 32'(ack), 32'(exp_ack));
      exp_ack = '0;
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 32'(out_valid), 0);
         end else begin
            check("out_sel", 32'(out_sel), q[0].sel);
            check("out_data", 32'(out_data), 32'(q[0].data));
            if (out_ready) begin
               exp_ack = 4'(1) << q[0].sel;
               void'(q.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      check("n3_ack_onehot", 32'($countones(ack3) <= 1), 1);
      if (!rst && out_valid3) begin
         check("n3_sel_range", 32'(out_sel3 < 2'd3), 1);
         if (q3.size() == 0) begin
            check("n3_unexpected_valid", 32'(out_valid3), 0);
         end else begin
            check("n3_out_sel", 32'(out_sel3), q3[0].sel);
            check("n3_out_data", 32'(out_data3), 32'(q3[0].data));
            void'(q3.pop_front());
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_sel", 32'(out_sel), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_ack", 32'(ack), 0);

      // Single request on ch2
      auto_drop = 1'b1;
      out_ready = 1'b1;
      req = 4'b0100;
      push(2, 8'hB1);
      tick();
      check("single_latency", 32'(out_valid), 1);
      check("single_busy", 32'(busy), 1);
      wait_drain(20);
      check("single_ack", 32'(ack), 32'(4'b0100));
      tick();
      check("single_idle", 32'(out_valid), 0);
      check("single_ack_clear", 32'(ack), 0);

      // All requesting, held; rr_ptr starts at 0
      do_reset();
      auto_drop = 1'b0;
      out_ready = 1'b1;
      req = 4'hF;
      push(0, 8'hD3); push(1, 8'hC2); push(2, 8'hB1); push(3, 8'hA0); push(0, 8'hD3);
      wait_drain(40);
      req = '0;
      tick();
      tick();
      check("all_idle", 32'(out_valid), 0);

      // Backpressure on ch1 while data_in changes
      auto_drop = 1'b1;
      out_ready = 1'b0;
      req = 4'b0010;
      push(1, 8'hC2);
      tick();
      for (int i = 0; i < 5; i++) begin
         data_in = $urandom;
         tick();
         check("bp_noack", 32'(ack), 0);
      end
      data_in = 32'hA0B1C2D3;
      out_ready = 1'b1;
      wait_drain(5);
      check("bp_ack", 32'(ack), 32'(4'b0010));
      tick();

      // Withdrawn request on ch3 is still delivered
      out_ready = 1'b0;
      req = 4'b1000;
      push(3, 8'hA0);
      tick();
      check("wd_busy", 32'(busy), 1);
      req = '0;
      tick();
      tick();
      out_ready = 1'b1;
      wait_drain(5);
      check("wd_ack", 32'(ack), 32'(4'b1000));
      tick();
      check("wd_idle", 32'(out_valid), 0);

      // Reset during a grant on ch2
      out_ready = 1'b0;
      req = 4'b0100;
      push(2, 8'hB1);
      tick();
      check("rg_valid", 32'(out_valid), 1);
      rst = 1'b1;
      tick();
      check("rg_valid_drop", 32'(out_valid), 0);
      check("rg_ack", 32'(ack), 0);
      check("rg_busy", 32'(busy), 0);
      check("rg_data_clr", 32'(out_data), 0);
      q.delete();
      rst = 1'b0;
      req = 4'b0001;
      out_ready = 1'b1;
      push(0, 8'hD3);
      wait_drain(10);
      check("rg_ack_ch0", 32'(ack), 32'(4'b0001));
      tick();

      // rr_ptr=1: ch1 before ch3, then wrap to ch0 before ch1
      req = 4'b1010;
      push(1, 8'hC2); push(3, 8'hA0);
      wait_drain(20);
      tick();
      req = 4'b0011;
      push(0, 8'hD3); push(1, 8'hC2);
      wait_drain(20);
      tick();
      tick();

      // N=3 instance, all requesting
      req = '0;
      do_reset();
      req3 = 3'b111;
      push3(0, 8'h33); push3(1, 8'h22); push3(2, 8'h11);
      push3(0, 8'h33); push3(1, 8'h22); push3(2, 8'h11);
      for (int n = 0; n < 40 && q3.size() != 0; n++) tick();
      check("n3_drain_timeout", q3.size(), 0);
      req3 = '0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
